// File: rtl/crtc_programmer_pkg.sv
// Shared constants, preset tables and FSM encoding
// for the CRTC register programmer.
package crtc_programmer_pkg;

    localparam int CRTC_REG_COUNT   = 14;
    localparam int CRTC_NUM_PRESETS = 2;

    typedef logic [0:CRTC_REG_COUNT-1][7:0] crtc_table_t;

    // Short frame so a simulated boot reaches v_sync quickly.
    localparam crtc_table_t CRTC_PRESET_SIM = {
        8'd5, 8'd3, 8'd4, 8'h11,
        8'd4, 8'd2, 8'd2, 8'd3,
        8'd0, 8'd2, 8'd0, 8'd0,
        8'd0, 8'd0
    };

    localparam crtc_table_t CRTC_PRESET_80COL = {
        8'd127, 8'd80, 8'd98, 8'h28,
        8'd38,  8'd0,  8'd32, 8'd34,
        8'h01,  8'd7,  8'h67, 8'd8,
        8'h06,  8'h00
    };

    typedef logic [2:0] crtc_prog_state_t;

    localparam crtc_prog_state_t ST_IDLE     = 3'd0;
    localparam crtc_prog_state_t ST_ARM_SEL  = 3'd1;
    localparam crtc_prog_state_t ST_HOLD_SEL = 3'd2;
    localparam crtc_prog_state_t ST_ARM_DAT  = 3'd3;
    localparam crtc_prog_state_t ST_HOLD_DAT = 3'd4;
    localparam crtc_prog_state_t ST_NEXT     = 3'd5;

    function automatic logic [7:0] crtc_sel_byte(
        input logic [4:0] idx
    );
        return {3'b000, idx};
    endfunction

endpackage

// File: rtl/crtc_preset_rom.sv
// Combinational preset table lookup: (preset, register) -> value.
// Out-of-range registers or presets read as zero.
module crtc_preset_rom
    import crtc_programmer_pkg::*;
#(
    parameter int NUM_PRESETS = CRTC_NUM_PRESETS
) (
    input  logic       preset_i,
    input  logic [4:0] index_i,
    output logic [7:0] value_o
);

    logic [3:0] idx;
    logic       in_range;

    assign idx      = index_i[3:0];
    assign in_range = (index_i < 5'(CRTC_REG_COUNT))
                   && (int'(preset_i) < NUM_PRESETS);

    always_comb begin
        value_o = 8'h00;
        if (in_range) begin
            unique case (preset_i)
                1'b0: value_o = CRTC_PRESET_SIM[idx];
                1'b1: value_o = CRTC_PRESET_80COL[idx];
            endcase
        end
    end

endmodule

// File: rtl/crtc_programmer.sv
// CPU-side CRTC bus initiator: boot-time table programming plus
// single register accesses, paced by the 1 MHz CPU clock enable.
module crtc_programmer
    import crtc_programmer_pkg::*;
#(
    parameter int REG_COUNT   = CRTC_REG_COUNT,
    parameter int NUM_PRESETS = CRTC_NUM_PRESETS
) (
    input  logic       sys_clock_i,
    input  logic       reset_i,
    input  logic       crtc_clk_en_i,
    input  logic       start_i,
    input  logic       preset_i,
    input  logic       req_i,
    input  logic       req_we_i,
    input  logic [4:0] req_reg_i,
    input  logic [7:0] req_data_i,
    output logic       ack_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       crtc_cs_o,
    output logic       crtc_we_o,
    output logic       crtc_rs_o,
    output logic [7:0] crtc_data_o,
    input  logic [7:0] crtc_data_i,
    input  logic       crtc_data_oe_i
);

    localparam int CW = $clog2(REG_COUNT);
    localparam logic [CW-1:0] LAST = CW'(REG_COUNT - 1);

    crtc_prog_state_t state_q, state_d;

    logic          boot_q,   boot_d;
    logic          preset_q, preset_d;
    logic          op_we_q,  op_we_d;
    logic [4:0]    reg_q,    reg_d;
    logic [7:0]    data_q,   data_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic          cs_q,     cs_d;
    logic          bwe_q,    bwe_d;
    logic          rs_q,     rs_d;
    logic [7:0]    bdata_q,  bdata_d;
    logic [7:0]    rdata_q,  rdata_d;

    logic [4:0]    sel_idx;
    logic [7:0]    rom_val;
    logic [7:0]    wr_val;
    logic          wr_op;
    logic          last_reg;

    assign sel_idx  = boot_q ? 5'(cnt_q) : reg_q;
    assign wr_op    = boot_q | op_we_q;
    assign wr_val   = boot_q ? rom_val : data_q;
    assign last_reg = (cnt_q == LAST);

    crtc_preset_rom #(
        .NUM_PRESETS(NUM_PRESETS)
    ) u_rom (
        .preset_i(preset_q),
        .index_i (sel_idx),
        .value_o (rom_val)
    );

    always_comb begin
        state_d  = state_q;
        boot_d   = boot_q;
        preset_d = preset_q;
        op_we_d  = op_we_q;
        reg_d    = reg_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        cs_d     = cs_q;
        bwe_d    = bwe_q;
        rs_d     = rs_q;
        bdata_d  = bdata_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                // Boot wins; a concurrent request stays pending.
                if (start_i) begin
                    state_d  = ST_ARM_SEL;
                    boot_d   = 1'b1;
                    preset_d = preset_i;
                    cnt_d    = '0;
                end else if (req_i) begin
                    state_d  = ST_ARM_SEL;
                    boot_d   = 1'b0;
                    op_we_d  = req_we_i;
                    reg_d    = req_reg_i;
                    data_d   = req_data_i;
                end
            end
            ST_ARM_SEL: begin
                if (crtc_clk_en_i) begin
                    cs_d    = 1'b1;
                    rs_d    = 1'b0;
                    bwe_d   = 1'b1;
                    bdata_d = crtc_sel_byte(sel_idx);
                    state_d = ST_HOLD_SEL;
                end
            end
            ST_HOLD_SEL: begin
                if (crtc_clk_en_i) begin
                    cs_d    = 1'b0;
                    bwe_d   = 1'b0;
                    bdata_d = 8'h00;
                    state_d = ST_ARM_DAT;
                end
            end
            ST_ARM_DAT: begin
                if (crtc_clk_en_i) begin
                    cs_d    = 1'b1;
                    rs_d    = 1'b1;
                    bwe_d   = wr_op;
                    bdata_d = wr_op ? wr_val : 8'h00;
                    state_d = ST_HOLD_DAT;
                end
            end
            ST_HOLD_DAT: begin
                if (crtc_clk_en_i) begin
                    cs_d    = 1'b0;
                    bwe_d   = 1'b0;
                    bdata_d = 8'h00;
                    if (!wr_op) begin
                        rdata_d = crtc_data_oe_i
                                ? crtc_data_i : 8'hFF;
                    end
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (boot_q && !last_reg) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_ARM_SEL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            boot_q   <= 1'b0;
            preset_q <= 1'b0;
            op_we_q  <= 1'b0;
            reg_q    <= 5'd0;
            data_q   <= 8'h00;
            cnt_q    <= '0;
            cs_q     <= 1'b0;
            bwe_q    <= 1'b0;
            rs_q     <= 1'b0;
            bdata_q  <= 8'h00;
            rdata_q  <= 8'hFF;
        end else begin
            state_q  <= state_d;
            boot_q   <= boot_d;
            preset_q <= preset_d;
            op_we_q  <= op_we_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            bwe_q    <= bwe_d;
            rs_q     <= rs_d;
            bdata_q  <= bdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_NEXT) && boot_q && last_reg;
    assign ack_o       = (state_q == ST_NEXT) && !boot_q;
    assign rdata_o     = rdata_q;
    assign crtc_cs_o   = cs_q;
    assign crtc_we_o   = bwe_q;
    assign crtc_rs_o   = rs_q;
    assign crtc_data_o = bdata_q;

endmodule

// File: tb/tb_crtc_programmer.sv
// Directed bench for crtc_programmer with a bus-level expectation
// queue checked by a single negedge monitor.
module tb_crtc_programmer;

    typedef struct {
        logic       rs;
        logic       we;
        logic [7:0] data;
        bit         first;
        bit         last;
        bit         boot;
        bit         rd;
        logic [7:0] rdata;
    } half_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       start = 1'b0;
    logic       preset = 1'b0;
    logic       req = 1'b0;
    logic       req_we = 1'b0;
    logic [4:0] req_reg = 5'd0;
    logic [7:0] req_data = 8'h00;
    logic [7:0] din = 8'h00;
    logic       oe = 1'b0;

    logic       ack, busy, done, cs, we, rs;
    logic [7:0] rdata, dout;

    int checks = 0;
    int errors = 0;
    int en_total = 0;
    int n_rise = 0;
    int n_done = 0;
    int n_ack = 0;
    int div = 0;
    int cnt_hi = 0;
    int cnt_lo = 0;
    logic en_edge = 1'b0;
    logic prev_cs = 1'b0;
    logic rise, fall, pulse_exp;

    half_t exp_q[$];
    half_t cur = '{default: 0};

    int sim_tab[14] = '{5, 3, 4, 'h11, 4, 2, 2, 3, 0, 2, 0, 0, 0, 0};

    crtc_programmer dut (
        .sys_clock_i   (clk),
        .reset_i       (rst),
        .crtc_clk_en_i (clk_en),
        .start_i       (start),
        .preset_i      (preset),
        .req_i         (req),
        .req_we_i      (req_we),
        .req_reg_i     (req_reg),
        .req_data_i    (req_data),
        .ack_o         (ack),
        .rdata_o       (rdata),
        .busy_o        (busy),
        .done_o        (done),
        .crtc_cs_o     (cs),
        .crtc_we_o     (we),
        .crtc_rs_o     (rs),
        .crtc_data_o   (dout),
        .crtc_data_i   (din),
        .crtc_data_oe_i(oe)
    );

    always #5 clk = ~clk;

    // 1 MHz enable: one clock in four
    always @(negedge clk) begin
        div = (div == 3) ? 0 : div + 1;
        clk_en = (div == 3);
    end

    always @(posedge clk) begin
        en_edge = clk_en;
        if (clk_en) en_total++;
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_cs = 1'b0;
            cnt_hi = 0;
            cnt_lo = 0;
        end else begin
            rise = cs && !prev_cs;
            fall = !cs && prev_cs;
            if (prev_cs && !rise) cnt_hi += int'(en_edge);
            if (!prev_cs) cnt_lo += int'(en_edge);
            if (rise) begin
                chk("rise_on_clk_en", en_edge, 1);
                chk("access_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    if (!cur.first) chk("idle_gap", cnt_lo, 1);
                    chk("rs", rs, cur.rs);
                    chk("we", we, cur.we);
                    if (cur.we) chk("data", dout, cur.data);
                    cur.data = dout;
                end
                n_rise++;
                cnt_hi = 0;
                cnt_lo = 0;
            end else if (cs) begin
                chk("rs_stable", rs, cur.rs);
                chk("we_stable", we, cur.we);
                chk("data_stable", dout, cur.data);
            end
            if (fall) begin
                chk("fall_on_clk_en", en_edge, 1);
                chk("cs_high_span", cnt_hi, 1);
                chk("we_idle", we, 0);
                chk("data_idle", dout, 0);
                cnt_hi = 0;
                cnt_lo = 0;
            end
            pulse_exp = fall && cur.last;
            chk("done_o", done, pulse_exp && cur.boot);
            chk("ack_o", ack, pulse_exp && !cur.boot);
            if (pulse_exp && !cur.boot && cur.rd)
                chk("rdata_o", rdata, cur.rdata);
            if (done) n_done++;
            if (ack) n_ack++;
            prev_cs = cs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return done;
            1: return ack;
            default: return busy;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int limit,
                            input string nm);
        int n = 0;
        while (n < limit && !sig(which)) begin
            tick();
            n++;
        end
        chk(nm, n < limit, 1);
    endtask

    task automatic align_en();
        int n = 0;
        while (n < 8 && !en_edge) begin
            tick();
            n++;
        end
        chk("align_timeout", n < 8, 1);
        repeat (3) tick();
    endtask

    task automatic push_boot();
        half_t h;
        for (int i = 0; i < 14; i++) begin
            h = '{rs: 1'b0, we: 1'b1, data: 8'(i), first: (i == 0),
                  last: 0, boot: 1, rd: 0, rdata: 8'h00};
            exp_q.push_back(h);
            h = '{rs: 1'b1, we: 1'b1, data: 8'(sim_tab[i]), first: 0,
                  last: (i == 13), boot: 1, rd: 0, rdata: 8'h00};
            exp_q.push_back(h);
        end
    endtask

    task automatic push_single(input logic w, input logic [4:0] r,
                               input logic [7:0] d,
                               input logic [7:0] rexp);
        half_t h;
        h = '{rs: 1'b0, we: 1'b1, data: {3'b000, r}, first: 1,
              last: 0, boot: 0, rd: 0, rdata: 8'h00};
        exp_q.push_back(h);
        h = '{rs: 1'b1, we: w, data: d, first: 0,
              last: 1, boot: 0, rd: !w, rdata: rexp};
        exp_q.push_back(h);
    endtask

    task automatic single(input logic w, input logic [4:0] r,
                          input logic [7:0] d, input logic [7:0] rexp);
        push_single(w, r, d, rexp);
        req = 1'b1;
        req_we = w;
        req_reg = r;
        req_data = d;
        wait_sig(2, 20, "req_accept_timeout");
        req = 1'b0;
        req_we = ~w;
        req_reg = 5'd31;
        req_data = 8'h5A;
        wait_sig(1, 200, "ack_timeout");
    endtask

    int en0, d0, a0, r0;

    initial begin
        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cs", cs, 0);
        chk("rst_we", we, 0);
        chk("rst_rs", rs, 0);
        chk("rst_data", dout, 8'h00);
        chk("rst_rdata", rdata, 8'hFF);
        rst = 1'b0;
        repeat (2) tick();

        // Boot from preset 0, accepted on a clk_en edge.
        d0 = n_done;
        r0 = n_rise;
        push_boot();
        align_en();
        start = 1'b1;
        tick();
        start = 1'b0;
        en0 = en_total;
        chk("busy_after_start", busy, 1);
        repeat (40) tick();
        preset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        preset = 1'b0;
        wait_sig(0, 400, "done_timeout");
        chk("boot_clk_en_count", en_total - en0, 56);
        tick();
        chk("busy_after_done", busy, 0);
        repeat (20) tick();
        chk("boot_done_once", n_done - d0, 1);
        chk("boot_half_count", n_rise - r0, 28);

        // Single write, then reads with and without oe.
        single(1'b1, 5'd12, 8'h10, 8'h00);
        tick();
        din = 8'h10;
        oe = 1'b1;
        single(1'b0, 5'd12, 8'h00, 8'h10);
        chk("rdata_r12", rdata, 8'h10);
        tick();
        oe = 1'b0;
        single(1'b0, 5'd12, 8'h00, 8'hFF);
        chk("rdata_no_oe", rdata, 8'hFF);
        tick();

        // Simultaneous start and request: boot first.
        d0 = n_done;
        a0 = n_ack;
        push_boot();
        push_single(1'b1, 5'd1, 8'h77, 8'h00);
        start = 1'b1;
        req = 1'b1;
        req_we = 1'b1;
        req_reg = 5'd1;
        req_data = 8'h77;
        tick();
        start = 1'b0;
        wait_sig(0, 400, "sim_done_timeout");
        chk("ack_after_boot", n_ack - a0, 0);
        wait_sig(1, 100, "sim_ack_timeout");
        req = 1'b0;
        tick();
        chk("sim_done_count", n_done - d0, 1);
        chk("sim_ack_count", n_ack - a0, 1);

        // Reset while holding the data half of register 7.
        repeat (3) tick();
        d0 = n_done;
        r0 = n_rise;
        push_boot();
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int n = 0;
            while (n < 400 && n_rise - r0 < 16) begin
                tick();
                n++;
            end
            chk("reg7_timeout", n < 400, 1);
        end
        chk("cs_before_reset", cs, 1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("abort_cs", cs, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("abort_no_done", n_done - d0, 0);
        push_boot();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig(0, 400, "reboot_done_timeout");
        tick();
        chk("reboot_done_count", n_done - d0, 1);

        // Back-to-back requests with req held across ack.
        repeat (3) tick();
        a0 = n_ack;
        push_single(1'b1, 5'd20, 8'hAB, 8'h00);
        req = 1'b1;
        req_we = 1'b1;
        req_reg = 5'd20;
        req_data = 8'hAB;
        wait_sig(1, 200, "b2b_ack1_timeout");
        push_single(1'b0, 5'd14, 8'h00, 8'h3C);
        req_we = 1'b0;
        req_reg = 5'd14;
        req_data = 8'h00;
        din = 8'h3C;
        oe = 1'b1;
        tick();
        chk("b2b_idle_gap", busy, 0);
        tick();
        chk("b2b_restart", busy, 1);
        req = 1'b0;
        wait_sig(1, 200, "b2b_ack2_timeout");
        chk("b2b_rdata", rdata, 8'h3C);
        repeat (30) tick();
        chk("b2b_ack_count", n_ack - a0, 2);
        chk("final_busy", busy, 0);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
